cache_fill_fsm: RTL and testbench

//  Miss handler that sits between the cache data/tag arrays and main memory.
//  - On a miss it optionally writes back the dirty victim line, then fetches a 4-word block of 16-bit words.
//  - Fill words are streamed into the data-array registers (dff_16bit cells).
//  - The tag/valid registers (dff_4bit / dff cells) are loaded on the final word.

---
 rtl/cache_fill_fsm.sv | 178 +++++++++++++++++
 tb/tb_cache_fill_fsm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss handler: optional dirty-line write-back, then 4-word block fill
//
// Optional feature macro: WRITEBACK_EN (write-back cache with the WB state).
// When WRITEBACK_EN is undefined the cache is write-through: victim_* inputs are unused and mem_wr is 0.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   miss_req, miss_addr      miss start and faulting byte address (captured in IDLE)
//   victim_dirty/addr/data   dirty flag, block-aligned address and word read of the victim line
//   word_idx                 data-array word index (write-back read index / fill write index)
//   cache_wen, cache_wdata   data-array fill write strobe and data
//   tag_wen                  tag/valid load strobe, asserted with the final fill word
//   mem_en, mem_wr           memory request strobe and direction (1 = write)
//   mem_addr, mem_wdata      memory byte address and write data
//   mem_rdata, mem_rvalid    in-order memory read returns
//   busy, done               busy outside IDLE; done pulses for one cycle at miss completion

module cache_fill_fsm #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [15:0]       victim_data,
    output logic [1:0]        word_idx,
    output logic              cache_wen,
    output logic [15:0]       cache_wdata,
    output logic              tag_wen,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              done
);

    localparam int BW = ADDR_W - 3;

    // With a latency of 4 or more no return can legitimately arrive before the
    // last read issues, so returns seen in FILL_REQ are stale (e.g. left over
    // from a reset mid-fill) and are dropped.
    localparam bit EARLY_RET = (MEM_LAT <= 3);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WB        = 3'd1,
        S_FILL_REQ  = 3'd2,
        S_FILL_WAIT = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    wb_cnt;
    logic [1:0]    iss_cnt;
    logic [1:0]    ret_cnt;
    logic [BW-1:0] miss_base;
    logic          accept;
    logic          ret_ok;

    assign accept = (state == S_IDLE) && miss_req;
    assign ret_ok = mem_rvalid &&
                    ((state == S_FILL_WAIT) || (EARLY_RET && (state == S_FILL_REQ)));

`ifdef WRITEBACK_EN
    logic [BW-1:0] victim_base;
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{miss_addr[2:0], victim_addr[2:0]};
`else
    logic          unused_victim;
    assign unused_victim = ^{miss_addr[2:0], victim_dirty, victim_addr, victim_data};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            wb_cnt    <= 2'd0;
            iss_cnt   <= 2'd0;
            ret_cnt   <= 2'd0;
            miss_base <= '0;
`ifdef WRITEBACK_EN
            victim_base <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                miss_base <= miss_addr[ADDR_W-1:3];
`ifdef WRITEBACK_EN
                victim_base <= victim_addr[ADDR_W-1:3];
`endif
                wb_cnt  <= 2'd0;
                iss_cnt <= 2'd0;
                ret_cnt <= 2'd0;
            end
            if (state == S_WB) begin
                wb_cnt <= wb_cnt + 2'd1;
            end
            if (state == S_FILL_REQ) begin
                iss_cnt <= iss_cnt + 2'd1;
            end
            // The final return wraps ret_cnt 3->0 on the same edge that enters DONE.
            if (ret_ok) begin
                ret_cnt <= ret_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        word_idx    = 2'd0;
        cache_wen   = 1'b0;
        cache_wdata = mem_rdata;
        tag_wen     = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 16'h0000;
        busy        = (state != S_IDLE);
        done        = 1'b0;

        case (state)
            S_IDLE: begin
                if (miss_req) begin
`ifdef WRITEBACK_EN
                    state_nxt = victim_dirty ? S_WB : S_FILL_REQ;
`else
                    state_nxt = S_FILL_REQ;
`endif
                end
            end
`ifdef WRITEBACK_EN
            S_WB: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {victim_base, wb_cnt, 1'b0};
                word_idx  = wb_cnt;
                mem_wdata = victim_data;
                if (wb_cnt == 2'd3) begin
                    state_nxt = S_FILL_REQ;
                end
            end
`endif
            S_FILL_REQ: begin
                mem_en   = 1'b1;
                mem_addr = {miss_base, iss_cnt, 1'b0};
                word_idx = ret_cnt;
                if (iss_cnt == 2'd3) begin
                    state_nxt = S_FILL_WAIT;
                end
            end
            S_FILL_WAIT: begin
                word_idx = ret_cnt;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (ret_ok) begin
            cache_wen = 1'b1;
            if (ret_cnt == 2'd3) begin
                tag_wen   = 1'b1;
                state_nxt = S_DONE;
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed self-checking bench for cache_fill_fsm

module tb_cache_fill_fsm;

    localparam int MEM_LAT = 4;
`ifdef WRITEBACK_EN
    localparam bit WB_BUILD = 1'b1;
`else
    localparam bit WB_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_req;
    logic [15:0] miss_addr;
    logic        victim_dirty;
    logic [15:0] victim_addr;
    logic [15:0] victim_data;
    logic [1:0]  word_idx;
    logic        cache_wen;
    logic [15:0] cache_wdata;
    logic        tag_wen;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        busy;
    logic        done;
    logic        spur_rv;

    int n_tests = 0;
    int n_fail  = 0;

    cache_fill_fsm #(.ADDR_W(16), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
        .word_idx(word_idx), .cache_wen(cache_wen), .cache_wdata(cache_wdata),
        .tag_wen(tag_wen), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Victim line: word i holds 0xB0+i.
    assign victim_data = 16'h00B0 + {14'd0, word_idx};

    // Memory: each read returns 0xA0 + word offset, MEM_LAT cycles after the request.
    logic [MEM_LAT-1:0] v_pipe = '0;
    logic [15:0]        d_pipe [MEM_LAT];
    always @(posedge clk) begin
        v_pipe <= {v_pipe[MEM_LAT-2:0], mem_en && !mem_wr};
        d_pipe[0] <= 16'h00A0 + {14'd0, mem_addr[2:1]};
        for (int i = 1; i < MEM_LAT; i++) d_pipe[i] <= d_pipe[i-1];
    end
    assign mem_rvalid = v_pipe[MEM_LAT-1] | spur_rv;
    assign mem_rdata  = d_pipe[MEM_LAT-1];

    // Drives one miss accepted at cycle 0 and checks every cycle up to and including done.
    task automatic run_miss(input string name, input logic [15:0] maddr, input logic dirty,
                            input logic [15:0] vaddr, input bit hold, input bit chg);
        int s, last;
        logic [15:0] mb;
        logic        e_wb, e_en, e_cw;
        logic [55:0] exp_v, act_v;
        logic [15:0] e_addr, e_cwd, e_mwd;
        logic [1:0]  e_idx;
        s    = (dirty && WB_BUILD) ? 4 : 0;
        last = 9 + s;
        mb   = {maddr[15:3], 3'b000};
        @(negedge clk);
        miss_req = 1'b1; miss_addr = maddr; victim_dirty = dirty; victim_addr = vaddr;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (!hold) miss_req = 1'b0;
            if (chg && c == 3) miss_addr = 16'h9990;
            e_wb   = (c <= s);
            e_en   = (c <= 4 + s);
            e_cw   = (c >= 5 + s) && (c <= 8 + s);
            e_addr = !e_en ? 16'h0000 : e_wb ? 16'(vaddr + 2 * (c - 1)) : 16'(mb + 2 * (c - 1 - s));
            e_cwd  = e_cw ? 16'(16'h00A0 + (c - 5 - s)) : 16'h0000;
            e_mwd  = e_wb ? 16'(16'h00B0 + (c - 1)) : 16'h0000;
            e_idx  = e_wb ? 2'(c - 1) : e_cw ? 2'(c - 5 - s) : 2'd0;
            exp_v = {e_en, e_en & e_wb, e_addr, e_cw, e_cwd, (c == 8 + s), (c == last), 1'b1,
                     e_idx, e_mwd};
            act_v = {mem_en, e_en ? mem_wr : 1'b0, mem_addr, cache_wen,
                     e_cw ? cache_wdata : 16'h0000, tag_wen, done, busy,
                     (e_wb | e_cw) ? word_idx : 2'd0, e_wb ? mem_wdata : 16'h0000};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, c, act_v, exp_v);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; miss_req = 1'b0; miss_addr = 16'h0; victim_dirty = 1'b0;
        victim_addr = 16'h0; spur_rv = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({word_idx, cache_wen, tag_wen, mem_en, mem_wr, mem_addr, busy, done} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected 0",
                     {word_idx, cache_wen, tag_wen, mem_en, mem_wr, mem_addr, busy, done});
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({word_idx, cache_wen, tag_wen, mem_en, mem_wr, mem_addr, busy, done} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected 0",
                     {word_idx, cache_wen, tag_wen, mem_en, mem_wr, mem_addr, busy, done});
        end
    endtask

    task automatic test_idle_rvalid;
        @(negedge clk);
        spur_rv = 1'b1;
        #1;
        n_tests++;
        if ({cache_wen, tag_wen, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_rvalid: got %b expected 000", {cache_wen, tag_wen, busy});
        end
        @(negedge clk);
        spur_rv = 1'b0;
        n_tests++;
        if ({cache_wen, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_rvalid_after: got %b expected 000", {cache_wen, busy, done});
        end
    endtask

    task automatic test_clean_miss;
        run_miss("clean_miss", 16'h1236, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

`ifdef WRITEBACK_EN
    task automatic test_dirty_miss;
        run_miss("dirty_miss", 16'h1236, 1'b1, 16'h4448, 1'b0, 1'b0);
    endtask
`else
    task automatic test_write_through_dirty;
        run_miss("wt_dirty", 16'h1236, 1'b1, 16'h4448, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_back_to_back;
        bit seen;
        run_miss("held_req", 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        n_tests++;
        if ({busy, mem_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL held_req_idle_gap: got %b expected 00", {busy, mem_en});
        end
        @(negedge clk);
        n_tests++;
        if ({busy, mem_en, mem_wr, mem_addr} !== {3'b110, 16'h9990}) begin
            n_fail++;
            $display("FAIL held_req_second: got %h expected %h",
                     {busy, mem_en, mem_wr, mem_addr}, {3'b110, 16'h9990});
        end
        miss_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL held_req_second_done: got no done expected done within 20 cycles");
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        miss_req = 1'b1; miss_addr = 16'h1236; victim_dirty = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            miss_req = 1'b0;
        end
        n_tests++;
        if ({cache_wen, word_idx, cache_wdata} !== {1'b1, 2'd1, 16'h00A1}) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got %h expected %h",
                     {cache_wen, word_idx, cache_wdata}, {1'b1, 2'd1, 16'h00A1});
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({word_idx, cache_wen, tag_wen, mem_en, mem_wr, mem_addr, busy, done} !== 24'd0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: got %h expected 0",
                     {word_idx, cache_wen, tag_wen, mem_en, mem_wr, mem_addr, busy, done});
        end
        rst = 1'b1;
        for (int c = 8; c <= 10; c++) begin
            @(negedge clk);
            n_tests++;
            if ({cache_wen, tag_wen, busy, done, mem_en} !== 5'b00000) begin
                n_fail++;
                $display("FAIL rst_mid_stale cycle %0d: got %b expected 00000",
                         c, {cache_wen, tag_wen, busy, done, mem_en});
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_rvalid();
        test_clean_miss();
`ifdef WRITEBACK_EN
        test_dirty_miss();
`else
        test_write_through_dirty();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
